// File: rtl/approx_mul_inverse_divider.sv
// Sequential unsigned restoring divider: recovers a W-bit quotient and remainder
// from a 2W-bit product and a W-bit operand, one quotient bit per clock.
module approx_mul_inverse_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] low_bits;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] trial_diff;
    logic [WIDTH-1:0] rem_next;
    logic             qbit;
    logic [WIDTH-1:0] upper;
    logic             is_zero;
    logic             is_ovf;

    assign upper    = dividend[2*WIDTH-1:WIDTH];
    assign is_zero  = (divisor == '0);
    assign is_ovf   = !is_zero && (upper >= divisor);
    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    // R < divisor always holds, so R fits in W bits; only the trial value needs W+1.
    always_comb begin
        trial      = {part_rem, low_bits[WIDTH-1]};
        qbit       = (trial >= {1'b0, div_reg});
        trial_diff = trial[WIDTH-1:0] - div_reg;
        rem_next   = qbit ? trial_diff : trial[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (is_zero || is_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flagged operations resolve on the accept edge and skip the iteration entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            part_rem    <= '0;
            low_bits    <= '0;
            div_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_zero) begin
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= dividend[WIDTH-1:0];
                        end else if (is_ovf) begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            quotient    <= '0;
                            div_reg     <= divisor;
                            part_rem    <= upper;
                            low_bits    <= dividend[WIDTH-1:0];
                            count       <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    part_rem <= rem_next;
                    low_bits <= {low_bits[WIDTH-2:0], 1'b0};
                    quotient <= {quotient[WIDTH-2:0], qbit};
                    if (count == '0) begin
                        remainder <= rem_next;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mul_inverse_divider.sv
// Self-checking bench for approx_mul_inverse_divider: directed vector table,
// reset/backpressure sequences and a randomised sweep against a reference model.
module tb_approx_mul_inverse_divider;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           ov;
        int             lat;
    } vec_t;

    vec_t vecs[10];

    approx_mul_inverse_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called #1 after a rising edge; returns with out_valid high (or timed out), lat counts edges incl. accept.
    task automatic applyStimulus(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
        int guard;
        guard = 0;
        lat   = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL in_ready timeout: got 0 expected 1");
            return;
        end
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat;
        applyStimulus(v.dvd, v.dvs, lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
        checkOutput({tag, " quotient"}, 32'(quotient), 32'(v.q));
        checkOutput({tag, " remainder"}, 32'(remainder), 32'(v.r));
        checkOutput({tag, " div_by_zero"}, 32'(div_by_zero), 32'(v.dz));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(v.ov));
        releaseResult();
        checkOutput({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " out_valid after release"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        logic [2*W-1:0] rd;
        logic [W-1:0]   rs;
        logic [W-1:0]   eq;
        logic [W-1:0]   er;
        logic           edz;
        logic           eov;
        int             elat;

        vecs[0] = '{16'h3039, 8'h64, 8'h7B, 8'h2D, 1'b0, 1'b0, 9};
        vecs[1] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
        vecs[2] = '{16'hFE01, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[3] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
        vecs[4] = '{16'h0010, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 9};
        vecs[5] = '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9};
        vecs[6] = '{16'h0000, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 9};
        vecs[7] = '{16'h0AFF, 8'h0B, 8'hFF, 8'h0A, 1'b0, 1'b0, 9};
        vecs[8] = '{16'h0505, 8'h05, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[9] = '{16'h00C8, 8'h01, 8'hC8, 8'h00, 1'b0, 1'b0, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset quotient", 32'(quotient), 32'd0);
        checkOutput("reset remainder", 32'(remainder), 32'd0);
        checkOutput("reset flags", 32'({div_by_zero, overflow}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an iteration must abandon it.
        dividend = 16'h3039;
        divisor  = 8'h64;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("midrun in_ready busy", 32'(in_ready), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun reset quotient", 32'(quotient), 32'd0);
        checkOutput("midrun reset remainder", 32'(remainder), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("midrun no stale result", 32'(out_valid), 32'd0);
        runVector(vecs[4], "post-reset op");

        // Backpressure: result holds and new requests are ignored while DONE.
        applyStimulus(16'h3039, 8'h64, lat);
        checkOutput("bp latency", 32'(lat), 32'd9);
        for (int c = 0; c < 5; c++) begin
            dividend = 16'h0010;
            divisor  = 8'h03;
            in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput($sformatf("bp c%0d out_valid", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp c%0d in_ready", c), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp c%0d quotient", c), 32'(quotient), 32'h7B);
            checkOutput($sformatf("bp c%0d remainder", c), 32'(remainder), 32'h2D);
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("bp nothing accepted", 32'(in_ready), 32'd1);

        // Random sweep against a behavioural division model.
        for (int n = 0; n < 2500; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            rs = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if (rs != 0 && $urandom_range(0, 1) == 1) begin
                rd = 16'(32'($urandom_range(0, 255)) * 32'(rs) + 32'($urandom_range(0, 32'(rs) - 1)));
            end else begin
                rd = 16'($urandom);
            end
            if (rs == 0) begin
                eq = 8'hFF; er = rd[7:0]; edz = 1'b1; eov = 1'b0; elat = 1;
            end else if (rd[15:8] >= rs) begin
                eq = 8'hFF; er = 8'h00; edz = 1'b0; eov = 1'b1; elat = 1;
            end else begin
                eq = 8'(rd / 16'(rs)); er = 8'(rd % 16'(rs)); edz = 1'b0; eov = 1'b0; elat = 9;
            end
            applyStimulus(rd, rs, lat);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            checkOutput($sformatf("rnd%0d latency", n), 32'(lat), 32'(elat));
            checkOutput($sformatf("rnd%0d quotient %0h/%0h", n, rd, rs), 32'(quotient), 32'(eq));
            checkOutput($sformatf("rnd%0d remainder %0h/%0h", n, rd, rs), 32'(remainder), 32'(er));
            checkOutput($sformatf("rnd%0d flags", n), 32'({div_by_zero, overflow}), 32'({edz, eov}));
            if (rs != 0 && rd[15:8] < rs) begin
                checkOutput($sformatf("rnd%0d identity", n), 32'(quotient) * 32'(rs) + 32'(remainder), 32'(rd));
                checkOutput($sformatf("rnd%0d rem<div", n), 32'(remainder < rs), 32'd1);
            end
            releaseResult();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
